// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: turns one-cycle event pulses into ON_LEN/OFF_LEN LED blinks and
// queues events that arrive mid-blink. Define LED_PWM_EN to add `duty` PWM dimming in ON.
module led_pulse_stretch #(
   parameter int unsigned ON_LEN      = 1000000,
   parameter int unsigned OFF_LEN     = 1000000,
   parameter int unsigned PEND_MAX    = 7,
   parameter int unsigned ACTIVE_HIGH = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            trig,
   input  logic                            clear,
   output logic                            led,
   output logic                            busy,
   output logic [$clog2(PEND_MAX+1)-1:0]   pending,
   output logic                            overflow
`ifdef LED_PWM_EN
   ,
   input  logic [7:0]                      duty
`endif
);

   localparam int unsigned MAXLEN = (ON_LEN > OFF_LEN) ? ON_LEN : OFF_LEN;
   localparam int unsigned CW     = $clog2(MAXLEN + 1);
   localparam int unsigned PW     = $clog2(PEND_MAX + 1);

   localparam logic [CW-1:0] ON_LOAD   = CW'(ON_LEN - 1);
   localparam logic [CW-1:0] OFF_LOAD  = CW'(OFF_LEN - 1);
   localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);
   localparam logic          LED_ON    = (ACTIVE_HIGH != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_GAP
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_pend;
   logic            r_ovf;
   logic            r_led;
   logic            r_busy;

   state_t          w_state_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [PW-1:0]   w_pend_nxt;
   logic            w_ovf_nxt;
   logic            w_last;
   logic            w_led_act;
   logic            w_busy_nxt;

`ifdef LED_PWM_EN
   logic [7:0]      r_pwm;
   logic [7:0]      w_pwm_nxt;

   assign w_pwm_nxt = r_pwm + 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= w_pwm_nxt;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_led   <= ~LED_ON;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_ovf   <= w_ovf_nxt;
         r_busy  <= w_busy_nxt;
         r_led   <= w_led_act ? LED_ON : ~LED_ON;
      end
   end

   assign w_last = (r_cnt == '0);

   // A trig on the last GAP cycle restarts ON directly; the queue is neither grown nor drained.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_ovf_nxt   = 1'b0;
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_pend_nxt  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (trig) begin
                  w_state_nxt = S_ON;
                  w_cnt_nxt   = ON_LOAD;
               end
            end
            S_ON: begin
               if (w_last) begin
                  w_state_nxt = S_GAP;
                  w_cnt_nxt   = OFF_LOAD;
               end else begin
                  w_cnt_nxt   = r_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (w_last) begin
                  if (trig || (r_pend != '0)) begin
                     w_state_nxt = S_ON;
                     w_cnt_nxt   = ON_LOAD;
                     if (!trig) begin
                        w_pend_nxt = r_pend - 1'b1;
                     end
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase

         if (trig && (r_state != S_IDLE) && !((r_state == S_GAP) && w_last)) begin
            if (r_pend == PEND_FULL) begin
               w_ovf_nxt = 1'b1;
            end else begin
               w_pend_nxt = r_pend + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_busy_nxt = (w_state_nxt != S_IDLE);
`ifdef LED_PWM_EN
      w_led_act  = (w_state_nxt == S_ON) && (w_pwm_nxt < duty);
`else
      w_led_act  = (w_state_nxt == S_ON);
`endif
   end

   assign led      = r_led;
   assign busy     = r_busy;
   assign pending  = r_pend;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Randomized plus directed bench for led_pulse_stretch, checked against a blink-position
// model; an ACTIVE_HIGH=0 twin shares stimulus. PWM section runs only with LED_PWM_EN.
module tb_led_pulse_stretch;

   localparam int ON_LEN   = 4;
   localparam int OFF_LEN  = 3;
   localparam int PEND_MAX = 2;
   localparam int PERIOD   = ON_LEN + OFF_LEN;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig;
   logic       clear;
   logic       led_hi, busy_hi, ovf_hi;
   logic       led_lo, busy_lo, ovf_lo;
   logic [1:0] pend_hi, pend_lo;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model: position within the current blink period plus queue depth
   bit         m_busy;
   int         m_pos;
   int         m_pend;
   bit         m_ovf;
   logic [7:0] m_pwm;

`ifdef LED_PWM_EN
   logic [7:0] duty;
   logic       trig_p, clear_p, led_p, busy_p, ovf_p;
   logic [1:0] pend_p;
   logic [7:0] duty_p;
   int         on_cnt;
`endif

   always #5 clk = ~clk;

   led_pulse_stretch #(.ON_LEN(ON_LEN), .OFF_LEN(OFF_LEN), .PEND_MAX(PEND_MAX), .ACTIVE_HIGH(1)) u_hi (
      .clk(clk), .rst(rst), .trig(trig), .clear(clear),
      .led(led_hi), .busy(busy_hi), .pending(pend_hi), .overflow(ovf_hi)
`ifdef LED_PWM_EN
      , .duty(duty)
`endif
   );

   led_pulse_stretch #(.ON_LEN(ON_LEN), .OFF_LEN(OFF_LEN), .PEND_MAX(PEND_MAX), .ACTIVE_HIGH(0)) u_lo (
      .clk(clk), .rst(rst), .trig(trig), .clear(clear),
      .led(led_lo), .busy(busy_lo), .pending(pend_lo), .overflow(ovf_lo)
`ifdef LED_PWM_EN
      , .duty(duty)
`endif
   );

`ifdef LED_PWM_EN
   led_pulse_stretch #(.ON_LEN(512), .OFF_LEN(3), .PEND_MAX(2), .ACTIVE_HIGH(1)) u_pwm (
      .clk(clk), .rst(rst), .trig(trig_p), .clear(clear_p),
      .led(led_p), .busy(busy_p), .pending(pend_p), .overflow(ovf_p), .duty(duty_p)
   );
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_pos  = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
      m_pwm  = 8'd0;
   endtask

   task automatic model_edge();
      bit last;
      m_ovf = 1'b0;
      m_pwm = m_pwm + 8'd1;
      if (clear) begin
         m_busy = 1'b0;
         m_pos  = 0;
         m_pend = 0;
      end else if (!m_busy) begin
         if (trig) begin
            m_busy = 1'b1;
            m_pos  = 0;
         end
      end else begin
         last = (m_pos == PERIOD - 1);
         if (trig && !last) begin
            if (m_pend == PEND_MAX) m_ovf = 1'b1;
            else                    m_pend++;
         end
         if (last) begin
            if (trig) begin
               m_pos = 0;
            end else if (m_pend > 0) begin
               m_pend--;
               m_pos = 0;
            end else begin
               m_busy = 1'b0;
               m_pos  = 0;
            end
         end else begin
            m_pos++;
         end
      end
   endtask

   function automatic logic exp_led_act();
`ifdef LED_PWM_EN
      return m_busy && (m_pos < ON_LEN) && (m_pwm < duty);
`else
      return m_busy && (m_pos < ON_LEN);
`endif
   endfunction

   task automatic compare_all();
      check("led_hi",  32'(led_hi),  32'(exp_led_act()));
      check("led_lo",  32'(led_lo),  32'(!exp_led_act()));
      check("busy_hi", 32'(busy_hi), 32'(m_busy));
      check("busy_lo", 32'(busy_lo), 32'(m_busy));
      check("pending", 32'(pend_hi), 32'(m_pend));
      check("pend_lo", 32'(pend_lo), 32'(m_pend));
      check("ovf",     32'(ovf_hi),  32'(m_ovf));
      check("ovf_lo",  32'(ovf_lo),  32'(m_ovf));
   endtask

   task automatic cyc(input logic t, input logic c);
      trig  = t;
      clear = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      trig  = 1'b0;
      clear = 1'b0;
      compare_all();
   endtask

   initial begin
      int hi_cnt;
      rst   = 1'b0;
      trig  = 1'b0;
      clear = 1'b0;
`ifdef LED_PWM_EN
      duty    = 8'd255;
      trig_p  = 1'b0;
      clear_p = 1'b0;
      duty_p  = 8'd64;
`endif
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_led_hi",  32'(led_hi),  32'd0);
      check("rst_led_lo",  32'(led_lo),  32'd1);
      check("rst_busy",    32'(busy_hi), 32'd0);
      check("rst_pending", 32'(pend_hi), 32'd0);
      check("rst_ovf",     32'(ovf_hi),  32'd0);
      rst = 1'b1;

      // single blink
      repeat (9) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      check("t1_led_first", 32'(led_hi), 32'd1);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 1'b0);
         check("t1_led",  32'(led_hi),  32'(i < 3));
         check("t1_busy", 32'(busy_hi), 32'(i < 6));
         check("t1_pend", 32'(pend_hi), 32'd0);
      end

      // three queued trigs during ON, third one overflows
      hi_cnt = 0;
      cyc(1'b1, 1'b0); hi_cnt += int'(led_hi);
      cyc(1'b1, 1'b0); hi_cnt += int'(led_hi);
      check("t2_pend1", 32'(pend_hi), 32'd1);
      cyc(1'b1, 1'b0); hi_cnt += int'(led_hi);
      check("t2_pend2", 32'(pend_hi), 32'd2);
      cyc(1'b1, 1'b0); hi_cnt += int'(led_hi);
      check("t2_pend_sat", 32'(pend_hi), 32'd2);
      check("t2_ovf",      32'(ovf_hi),  32'd1);
      cyc(1'b0, 1'b0); hi_cnt += int'(led_hi);
      check("t2_ovf_end",  32'(ovf_hi),  32'd0);
      for (int i = 0; i < 22; i++) begin
         cyc(1'b0, 1'b0);
         hi_cnt += int'(led_hi);
      end
      check("t2_on_cycles", 32'(hi_cnt),  32'd12);
      check("t2_idle",      32'(busy_hi), 32'd0);

      // trig on the last GAP cycle, pending 0 then pending 1
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 10 && m_pos != PERIOD - 1; i++) cyc(1'b0, 1'b0);
      check("t3_at_last", 32'(m_pos), 32'(PERIOD - 1));
      cyc(1'b1, 1'b0);
      check("t3_busy0", 32'(busy_hi), 32'd1);
      check("t3_led0",  32'(led_hi),  32'd1);
      check("t3_pend0", 32'(pend_hi), 32'd0);
      cyc(1'b1, 1'b0);
      check("t3_pend_q", 32'(pend_hi), 32'd1);
      for (int i = 0; i < 10 && m_pos != PERIOD - 1; i++) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      check("t3_busy1", 32'(busy_hi), 32'd1);
      check("t3_pend1", 32'(pend_hi), 32'd1);
      repeat (20) cyc(1'b0, 1'b0);
      check("t3_drained", 32'(busy_hi), 32'd0);

      // clear with queued events and a simultaneous trig
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("t4_pend_pre", 32'(pend_hi), 32'd2);
      cyc(1'b1, 1'b1);
      check("t4_led",  32'(led_hi),  32'd0);
      check("t4_busy", 32'(busy_hi), 32'd0);
      check("t4_pend", 32'(pend_hi), 32'd0);
      hi_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 1'b0);
         hi_cnt += int'(busy_hi);
      end
      check("t4_no_blinks", 32'(hi_cnt), 32'd0);

      // asynchronous reset in the middle of ON
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      check("t5_on", 32'(led_hi), 32'd1);
      #3 rst = 1'b0;
      #1;
      check("t5_async_hi", 32'(led_hi),  32'd0);
      check("t5_async_lo", 32'(led_lo),  32'd1);
      check("t5_busy",     32'(busy_hi), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b1, 1'b0);
      check("t5_reblink", 32'(led_hi), 32'd1);
      repeat (10) cyc(1'b0, 1'b0);

`ifdef LED_PWM_EN
      // PWM dimming over a 512-cycle ON phase
      for (int k = 0; k < 2; k++) begin
         duty_p = (k == 0) ? 8'd64 : 8'd0;
         trig_p = 1'b1;
         cyc(1'b0, 1'b0);
         trig_p = 1'b0;
         on_cnt = int'(led_p);
         for (int i = 0; i < 520; i++) begin
            cyc(1'b0, 1'b0);
            on_cnt += int'(led_p);
         end
         check("t6_pwm_on", 32'(on_cnt), (k == 0) ? 32'd128 : 32'd0);
         check("t6_idle",   32'(busy_p), 32'd0);
      end
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
